// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, NOP word,
// reset PC default and instruction field positions used by the instruction register.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        WRITE = 2'b10
    } fetch_state_t;

    localparam logic [15:0] NOP_WORD         = 16'h0000;
    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    // Instruction field positions, shared with the instruction register
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;
    localparam int FUNC_MSB   = 3;
    localparam int FUNC_LSB   = 0;

endpackage

// File: rtl/instruction_fetch_unit_program_counter.sv
// Program counter: direct load when idle, one-entry pending load while a fetch is
// in flight, and wrap-around increment on instruction capture.
module program_counter #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_value,
    input  logic              hold,
    input  logic              commit,
    input  logic              increment,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pend_value_reg;
    logic              pend_valid_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg         <= RESET_PC;
            pend_value_reg <= '0;
            pend_valid_reg <= 1'b0;
        end else if (!hold) begin
            if (load) begin
                pc_reg <= load_value;
            end
            pend_valid_reg <= 1'b0;
        end else if (commit) begin
            // A load arriving on the commit edge is the newest target and wins.
            if (load) begin
                pc_reg <= load_value;
            end else if (pend_valid_reg) begin
                pc_reg <= pend_value_reg;
            end else if (increment) begin
                pc_reg <= pc_reg + 1'b1;
            end
            pend_valid_reg <= 1'b0;
        end else if (load) begin
            pend_value_reg <= load_value;
            pend_valid_reg <= 1'b1;
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC plus request/ready handshake to instruction memory,
// feeding the instruction register. Optional timeout enabled by FETCH_TIMEOUT_EN.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(RESET_PC_DEFAULT),
    parameter int                TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              C_FetchReq,
    input  logic              C_PCWrite,
    input  logic [ADDR_W-1:0] D_PCNext,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [15:0]       D_MemData,
    output logic              C_IRWrite,
    output logic              fetch_done,
    output logic [ADDR_W-1:0] D_PC,
    output logic              busy,
    output logic              fetch_fault
);

    fetch_state_t      state_reg;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [15:0]       mem_data_reg;
    logic              accept;
    logic              capture;
    logic              timeout;
    logic              fault_reg;

    assign accept  = (state_reg == IDLE) && C_FetchReq;
    assign capture = (state_reg == REQ) && mem_ready;

`ifdef FETCH_TIMEOUT_EN
    logic [3:0] wait_cnt_reg;

    assign timeout = (state_reg == REQ) && !mem_ready && (wait_cnt_reg == 4'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_reg <= 4'd0;
            fault_reg    <= 1'b0;
        end else begin
            if ((state_reg == REQ) && !mem_ready) begin
                wait_cnt_reg <= wait_cnt_reg + 4'd1;
            end else begin
                wait_cnt_reg <= 4'd0;
            end
            if (accept) begin
                fault_reg <= 1'b0;
            end else if (timeout) begin
                fault_reg <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYC[3:0];
    assign timeout            = 1'b0;
    assign fault_reg          = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (C_FetchReq) state_next = REQ;
            REQ:     if (mem_ready || timeout) state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            mem_addr_reg <= '0;
            mem_data_reg <= NOP_WORD;
        end else begin
            state_reg <= state_next;
            // A jump in the same cycle as the request redirects this fetch.
            if (accept) begin
                mem_addr_reg <= C_PCWrite ? D_PCNext : D_PC;
            end
            if (capture) begin
                mem_data_reg <= mem_rdata;
            end else if (timeout) begin
                mem_data_reg <= NOP_WORD;
            end
        end
    end

    // Pending jumps stored during WRITE are committed on its exit edge so none linger.
    program_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .load       (C_PCWrite),
        .load_value (D_PCNext),
        .hold       (state_reg != IDLE),
        .commit     (capture || timeout || (state_reg == WRITE)),
        .increment  (capture),
        .pc         (D_PC)
    );

    assign mem_req     = (state_reg == REQ);
    assign mem_addr    = mem_addr_reg;
    assign D_MemData   = mem_data_reg;
    assign busy        = (state_reg != IDLE);
    assign fetch_done  = (state_reg == WRITE);
    assign C_IRWrite   = (state_reg == WRITE) && !fault_reg;
    assign fetch_fault = fault_reg;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Supplier side of the instruction register interface in the 16-bit multi-cycle datapath.
- Holds the program counter and runs a request/ready read handshake with instruction memory.
- Captures the returned word onto D_MemData and pulses C_IRWrite so the instruction register latches it.
- Sequenced by the main control FSM through C_FetchReq and C_PCWrite.

Parameters:
- ADDR_W, 16, PC and memory address width; the PC is word-addressed.
- RESET_PC, 16'h0000, PC value after reset.
- TIMEOUT_CYC, 15, maximum wait cycles for mem_ready; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- C_FetchReq  in  1  one-cycle fetch request from control.
- C_PCWrite  in  1  load the PC from D_PCNext (jump/branch).
- D_PCNext  in  ADDR_W  target PC for jump/branch.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  ADDR_W  read address; stable while mem_req=1.
- mem_rdata  in  16  instruction word; valid only when mem_ready=1.
- mem_ready  in  1  memory accepts the request and returns data in the same cycle.
- D_MemData  out  16  captured instruction word, to the instruction register.
- C_IRWrite  out  1  one-cycle instruction register load strobe.
- fetch_done  out  1  one-cycle completion pulse to control.
- D_PC  out  ADDR_W  current PC.
- busy  out  1  high in REQ and WRITE.
- fetch_fault  out  1  timeout flag; tied to 0 without FETCH_TIMEOUT_EN.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; D_PC=RESET_PC.
  - mem_req=0, mem_addr=0, D_MemData=16'h0000.
  - C_IRWrite=0, fetch_done=0, busy=0, fetch_fault=0.
  - A reset mid-fetch drops mem_req immediately and discards the transaction.
- IDLE:
  - C_FetchReq=1 moves to REQ and registers mem_addr from D_PC.
  - C_FetchReq=1 together with C_PCWrite=1 in the same cycle: D_PC and mem_addr both take D_PCNext, so the new target is fetched.
  - C_PCWrite=1 alone loads D_PC.
- REQ:
  - mem_req=1 and mem_addr held constant until mem_ready=1 is sampled.
  - On the mem_ready edge: D_MemData<=mem_rdata, D_PC<=D_PC+1 (16'hFFFF wraps to 16'h0000), then go to WRITE.
  - mem_rdata is ignored whenever mem_ready=0.
- WRITE:
  - C_IRWrite=1 and fetch_done=1 for exactly one cycle, then return to IDLE.
  - mem_req=0.
- Latency: C_FetchReq at edge N gives mem_req high from N+1. With zero-wait memory, C_IRWrite is high during the cycle after edge N+2, so the minimum cadence is 3 cycles per fetch.
- Busy-state inputs:
  - C_FetchReq while busy is ignored; it is not queued.
  - C_PCWrite while busy is stored in a one-entry pending register. It is applied on the capture edge and overrides the +1 increment.
  - A later C_PCWrite overwrites an earlier pending one.
- D_MemData holds its value until the next capture.
- fetch_fault is cleared by the next accepted C_FetchReq.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A 4-bit wait counter runs in REQ.
  - After TIMEOUT_CYC cycles with mem_ready=0: mem_req drops, fetch_fault=1, D_MemData<=16'h0000 (NOP).
  - fetch_done pulses; C_IRWrite stays 0; the PC is not incremented; any pending PC write is still applied.
- Undefined: REQ waits indefinitely and fetch_fault is constant 0.

Decomposition:
- Package fetch_pkg holds:
  - state encoding IDLE=2'b00, REQ=2'b01, WRITE=2'b10;
  - NOP_WORD=16'h0000;
  - RESET_PC default;
  - instruction field positions (opcode [15:12], funcfield [3:0]) shared with the instruction register.
- One natural sub-module: program_counter, holding D_PC, the increment with wrap, the direct load and the pending-load register.
- The FSM and handshake stay in the top module.

Test Plan:
- Reset then C_FetchReq with memory returning 16'h8B48 on its first request cycle:
  - mem_addr=0x0000;
  - C_IRWrite pulses once with D_MemData=16'h8B48;
  - D_PC=0x0001.
- Memory inserts 3 wait cycles:
  - mem_req and mem_addr stay stable for 4 cycles;
  - the capture value is 16'h2BC9;
  - C_IRWrite does not assert early.
- C_PCWrite with D_PCNext=0x0378 in the same cycle as C_FetchReq: mem_addr=0x0378 and D_PC=0x0379 after the fetch.
- D_PC=0xFFFF, fetch completes → D_PC=0x0000. A C_PCWrite with 0x0040 arriving while in REQ gives D_PC=0x0040 after capture.
- rst asserted low during REQ → mem_req drops the same cycle and every output takes its reset value.
- With FETCH_TIMEOUT_EN and mem_ready held at 0:
  - after 15 REQ cycles fetch_fault=1, fetch_done pulses, C_IRWrite=0, D_MemData=16'h0000;
  - the next C_FetchReq clears fetch_fault.
